mem_wb_pipe_stage: RTL and testbench

Parametrised MEM→WB pipeline stage register for the five-stage core. It replaces a fixed-width latch with a 2-entry elastic stage: a main entry plus a skid entry, driven by a valid/ready handshake. It also provides flush, a forwarding tap that selects the write-back value, and a saturating stall-cycle counter. It sits between the memory stage and the register-file write port.

---
 rtl/mem_wb_pipe_stage_pkg.sv | 33 +++
 rtl/mem_wb_pipe_stage_if.sv | 43 ++++
 rtl/mem_wb_pipe_stage_skid_entry.sv | 34 +++
 rtl/mem_wb_pipe_stage.sv | 117 +++++++++++
 tb/tb_mem_wb_pipe_stage.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_pipe_stage_pkg.sv
// Shared types for the MEM->WB elastic stage: payload layout, default
// widths and the occupancy-derived stage state.
package mem_wb_pipe_stage_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 3;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] mem_data;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [ADDR_W_DEF-1:0] rdst;
    logic                  mem_read;
    logic                  reg_write;
  } mem_wb_payload_t;

  localparam int PAYLOAD_W = $bits(mem_wb_payload_t);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // The skid entry is only ever valid while the head is valid, so the
  // skid bit alone identifies FULL.
  function automatic stage_state_e decode_state(input logic head_v,
                                                input logic skid_v);
    if (skid_v)      return ST_FULL;
    else if (head_v) return ST_ONE;
    else             return ST_EMPTY;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_stage_if.sv
// Handshake and payload bundle between the memory stage, the MEM->WB
// stage and the register-file write port.
interface mem_wb_pipe_stage_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_mem_data;
  logic [DATA_W-1:0] in_alu_result;
  logic [ADDR_W-1:0] in_rdst;
  logic              in_mem_read;
  logic              in_reg_write;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_mem_data;
  logic [DATA_W-1:0] out_alu_result;
  logic [ADDR_W-1:0] out_rdst;
  logic              out_mem_read;
  logic              out_reg_write;
  logic              wb_en;
  logic [DATA_W-1:0] wb_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  // Environment side: drives the memory-stage inputs and write-back ready.
  modport master (
    output in_valid, in_mem_data, in_alu_result, in_rdst, in_mem_read,
           in_reg_write, flush, out_ready,
    input  in_ready, out_valid, out_mem_data, out_alu_result, out_rdst,
           out_mem_read, out_reg_write, wb_en, wb_data, occupancy, stall_cnt
  );

  // Stage side.
  modport slave (
    input  in_valid, in_mem_data, in_alu_result, in_rdst, in_mem_read,
           in_reg_write, flush, out_ready,
    output in_ready, out_valid, out_mem_data, out_alu_result, out_rdst,
           out_mem_read, out_reg_write, wb_en, wb_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/mem_wb_pipe_stage_skid_entry.sv
// One payload register with its valid bit. Clear wins over load and
// leaves the payload untouched.
module pipe_skid_entry #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [W-1:0] d_i,
  output logic         valid_o,
  output logic [W-1:0] q_o
);

  logic         valid_q;
  logic [W-1:0] data_q;

  // Valid bit and payload update; payload only changes on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB elastic stage: head + skid entry behind a valid/ready
// handshake, with flush, write-back select and a saturating stall counter.
module mem_wb_pipe_stage
  import mem_wb_pipe_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_wb_pipe_stage_if.slave bus
);

  localparam int PW = 2 * DATA_W + ADDR_W + 2;

  logic [PW-1:0]    in_pl;
  logic [PW-1:0]    head_pl;
  logic [PW-1:0]    skid_pl;
  logic [PW-1:0]    head_d;
  logic             head_v;
  logic             skid_v;
  logic             head_load;
  logic             head_clr;
  logic             skid_load;
  logic             skid_clr;
  logic             accept;
  logic             consume;
  stage_state_e     state;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             head_mem_read;
  logic             head_reg_write;

  assign in_pl   = {bus.in_mem_data, bus.in_alu_result, bus.in_rdst,
                    bus.in_mem_read, bus.in_reg_write};
  assign state   = decode_state(head_v, skid_v);
  assign accept  = bus.in_valid & ~skid_v;
  assign consume = head_v & bus.out_ready;

  // Entry control: FIFO order, flush overrides every load.
  always_comb begin
    head_load = 1'b0;
    head_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    head_d    = in_pl;
    case (state)
      ST_EMPTY: head_load = accept;
      ST_ONE: begin
        if (accept && consume) head_load = 1'b1;
        else if (accept)       skid_load = 1'b1;
        else if (consume)      head_clr  = 1'b1;
      end
      ST_FULL: begin
        if (consume) begin
          head_load = 1'b1;
          head_d    = skid_pl;
          skid_clr  = 1'b1;
        end
      end
      default: ;
    endcase
    if (bus.flush) begin
      head_load = 1'b0;
      skid_load = 1'b0;
      head_clr  = 1'b1;
      skid_clr  = 1'b1;
    end
  end

  pipe_skid_entry #(.W(PW)) u_head (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (head_load),
    .clr_i   (head_clr),
    .d_i     (head_d),
    .valid_o (head_v),
    .q_o     (head_pl)
  );

  pipe_skid_entry #(.W(PW)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clr_i   (skid_clr),
    .d_i     (in_pl),
    .valid_o (skid_v),
    .q_o     (skid_pl)
  );

  // Stall counter next value: count head-valid cycles with no ready, saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (head_v && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign {bus.out_mem_data, bus.out_alu_result, bus.out_rdst,
          head_mem_read, head_reg_write} = head_pl;

  assign bus.in_ready      = ~skid_v;
  assign bus.out_valid     = head_v;
  assign bus.out_mem_read  = head_v & head_mem_read;
  assign bus.out_reg_write = head_v & head_reg_write;
  assign bus.wb_en         = head_v & head_reg_write & bus.out_ready;
  assign bus.wb_data       = bus.out_mem_read ? bus.out_mem_data : bus.out_alu_result;
  assign bus.occupancy     = {1'b0, head_v} + {1'b0, skid_v};
  assign bus.stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Randomized bench with a queue-based reference model of the MEM->WB stage,
// plus directed scenarios pinned to literal expectations.
module tb_mem_wb_pipe_stage;
  import mem_wb_pipe_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_pipe_stage_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) bus ();
  mem_wb_pipe_stage_if #(.DATA_W(16), .ADDR_W(3), .CNT_W(4)) bus4 ();

  mem_wb_pipe_stage #(.DATA_W(16), .ADDR_W(3), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mem_wb_pipe_stage #(.DATA_W(16), .ADDR_W(3), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4.slave)
  );

  assign bus4.in_valid      = bus.in_valid;
  assign bus4.in_mem_data   = bus.in_mem_data;
  assign bus4.in_alu_result = bus.in_alu_result;
  assign bus4.in_rdst       = bus.in_rdst;
  assign bus4.in_mem_read   = bus.in_mem_read;
  assign bus4.in_reg_write  = bus.in_reg_write;
  assign bus4.flush         = bus.flush;
  assign bus4.out_ready     = bus.out_ready;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  mem_wb_payload_t m_q[$];
  int unsigned     m_cnt  = 0;
  int unsigned     m_cnt4 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] md, input logic [15:0] alu,
                       input logic [2:0] rd, input logic mr, input logic rw,
                       input logic ordy, input logic fl);
    bus.in_valid      = v;
    bus.in_mem_data   = md;
    bus.in_alu_result = alu;
    bus.in_rdst       = rd;
    bus.in_mem_read   = mr;
    bus.in_reg_write  = rw;
    bus.out_ready     = ordy;
    bus.flush         = fl;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt  = 0;
    m_cnt4 = 0;
  endtask

  // Model: a two-deep FIFO, evaluated with the inputs seen at the edge.
  task automatic model_edge();
    mem_wb_payload_t p;
    bit acc;
    bit con;
    p.mem_data   = bus.in_mem_data;
    p.alu_result = bus.in_alu_result;
    p.rdst       = bus.in_rdst;
    p.mem_read   = bus.in_mem_read;
    p.reg_write  = bus.in_reg_write;
    acc = bus.in_valid && (m_q.size() < 2);
    con = (m_q.size() > 0) && bus.out_ready;
    if ((m_q.size() > 0) && !bus.out_ready) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (bus.flush) m_q.delete();
    else begin
      if (con) void'(m_q.pop_front());
      if (acc) m_q.push_back(p);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic ov;
      mem_wb_payload_t h;
      ov = (m_q.size() > 0);
      h  = ov ? m_q[0] : '0;
      chk("in_ready",  32'(bus.in_ready),      32'(m_q.size() < 2));
      chk("out_valid", 32'(bus.out_valid),     32'(ov));
      chk("occupancy", 32'(bus.occupancy),     32'(m_q.size()));
      chk("stall_cnt", 32'(bus.stall_cnt),     m_cnt);
      chk("stall_cnt4",32'(bus4.stall_cnt),    m_cnt4);
      chk("out_mem_read",  32'(bus.out_mem_read),  32'(ov && h.mem_read));
      chk("out_reg_write", 32'(bus.out_reg_write), 32'(ov && h.reg_write));
      chk("wb_en", 32'(bus.wb_en), 32'(ov && h.reg_write && bus.out_ready));
      if (ov) begin
        chk("out_mem_data",   32'(bus.out_mem_data),   32'(h.mem_data));
        chk("out_alu_result", 32'(bus.out_alu_result), 32'(h.alu_result));
        chk("out_rdst",       32'(bus.out_rdst),       32'(h.rdst));
        chk("wb_data", 32'(bus.wb_data),
            32'(h.mem_read ? h.mem_data : h.alu_result));
      end
    end
  end

  initial begin
    logic [7:0] saved;
    drive(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
    model_reset();
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("rst_alu",       32'(bus.out_alu_result), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    step();

    // Streaming 1..10 with ready held high.
    for (int i = 1; i <= 10; i++) begin
      drive(1, 16'h0, 16'(i), 3'd1, 0, 1, 1, 0);
      step();
      chk("stream_alu", 32'(bus.out_alu_result), 32'(i));
      chk("stream_occ", 32'(bus.occupancy), 32'd1);
    end
    drive(0, 16'h0, 16'h0, 3'd0, 0, 0, 1, 0);
    step();
    chk("stream_stall", 32'(bus.stall_cnt), 32'd0);
    chk("stream_drain", 32'(bus.occupancy), 32'd0);

    // Backpressure: A then B, three stalled head cycles.
    drive(1, 16'h0, 16'h1111, 3'd2, 0, 1, 0, 0);
    step();
    chk("bp_occ_a", 32'(bus.occupancy), 32'd1);
    drive(1, 16'h0, 16'h2222, 3'd3, 0, 1, 0, 0);
    step();
    chk("bp_occ_b", 32'(bus.occupancy), 32'd2);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    drive(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
    step();
    step();
    chk("bp_stall", 32'(bus.stall_cnt), 32'd3);
    chk("bp_head_a", 32'(bus.out_alu_result), 32'h1111);
    bus.out_ready = 1'b1;
    step();
    chk("bp_head_b", 32'(bus.out_alu_result), 32'h2222);
    chk("bp_occ_1", 32'(bus.occupancy), 32'd1);
    step();
    chk("bp_empty", 32'(bus.out_valid), 32'd0);

    // Load select.
    drive(1, 16'hBEEF, 16'h1234, 3'd5, 1, 1, 0, 0);
    step();
    drive(1, 16'h5555, 16'h1234, 3'd5, 0, 1, 1, 0);
    #1;
    chk("ld_wb_en",   32'(bus.wb_en),    32'd1);
    chk("ld_wb_data", 32'(bus.wb_data),  32'hBEEF);
    chk("ld_rdst",    32'(bus.out_rdst), 32'd5);
    step();
    chk("alu_wb_data", 32'(bus.wb_data), 32'h1234);
    drive(0, 16'h0, 16'h0, 3'd0, 0, 0, 1, 0);
    step();

    // Flush while FULL with an incoming instruction.
    drive(1, 16'h0, 16'h0A0A, 3'd1, 0, 1, 0, 0);
    step();
    drive(1, 16'h0, 16'h0B0B, 3'd2, 0, 1, 0, 0);
    step();
    chk("fl_full", 32'(bus.occupancy), 32'd2);
    saved = bus.stall_cnt;
    drive(1, 16'h0, 16'h0C0C, 3'd3, 0, 1, 1, 1);
    #1;
    chk("fl_wb_en_same_cycle", 32'(bus.wb_en), 32'd1);
    step();
    drive(0, 16'h0, 16'h0, 3'd0, 0, 0, 1, 0);
    #1;
    chk("fl_occ", 32'(bus.occupancy), 32'd0);
    chk("fl_out_valid", 32'(bus.out_valid), 32'd0);
    chk("fl_wb_en", 32'(bus.wb_en), 32'd0);
    chk("fl_stall", 32'(bus.stall_cnt), 32'(saved));
    step();
    chk("fl_not_captured", 32'(bus.occupancy), 32'd0);

    // Asynchronous reset while FULL.
    drive(1, 16'h0, 16'h0D0D, 3'd1, 0, 1, 0, 0);
    step();
    drive(1, 16'h0, 16'h0E0E, 3'd2, 0, 1, 0, 0);
    step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_occ",       32'(bus.occupancy), 32'd0);
    chk("ar_stall",     32'(bus.stall_cnt), 32'd0);
    chk("ar_in_ready",  32'(bus.in_ready),  32'd1);
    #2;
    rst_n = 1'b1;
    drive(1, 16'h0, 16'h00AB, 3'd4, 0, 1, 0, 0);
    step();
    chk("ar_first_valid", 32'(bus.out_valid), 32'd1);
    chk("ar_first_alu", 32'(bus.out_alu_result), 32'h00AB);

    // Saturation: 20 stalled cycles.
    drive(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_cnt4", 32'(bus4.stall_cnt), 32'd15);
    chk("sat_cnt8", 32'(bus.stall_cnt), 32'd20);
    chk("sat_occ",  32'(bus.occupancy), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom),
            3'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
      step();
    end

    drive(0, 16'h0, 16'h0, 3'd0, 0, 0, 1, 0);
    step();
    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
